// File: rtl/demux1to4_buffered_if.sv
// Bus bundle for the buffered 1-to-4 demux: one producer port in,
// four valid/ready consumer channels out, plus status.
interface demux1to4_buffered_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic [1:0]           in_sel;
  logic [WIDTH-1:0]     in_data;
  logic                 in_ready;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [4*WIDTH-1:0]   out_data;
  logic [7:0]           level;
  logic                 overflow_err;

  // Producer/consumer side (drives the stream, takes the channels).
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, overflow_err
  );

  // Demux side.
  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, level, overflow_err
  );
endinterface

// File: rtl/demux1to4_buffered.sv
// Buffered 1-to-4 demux: each input word is steered by in_sel into one of
// four independent 2-entry FIFOs, so a stalled consumer only blocks words
// bound for its own channel.

// One channel FIFO. Pointers are {wrap, index}; equal pointers mean empty,
// equal index with differing wrap means full.
module demux1to4_buffered_chan #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             valid_o,
  output logic             full_o,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       level_o
);
  logic [1:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q;

  assign valid_o = (wr_q != rd_q);
  assign full_o  = (wr_q[0] == rd_q[0]) && (wr_q[1] != rd_q[1]);
  assign head_o  = mem_q[rd_q[0]];
  // Modular pointer difference is the occupancy (0..2).
  assign level_o = wr_q - rd_q;

  // Pointer advance; push/pop are already qualified by the caller.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 2'd1;
    if (pop_i)  rd_d = rd_q + 2'd1;
  end

  // Pointer and storage registers; storage is cleared so out_data reads 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_i) mem_q[wr_q[0]] <= wdata_i;
    end
  end
endmodule

module demux1to4_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1to4_buffered_if.slave   bus
);
  localparam int NUM_CH = 4;

  logic [NUM_CH-1:0]             dec, push, pop, full, valid;
  logic [NUM_CH-1:0][WIDTH-1:0]  head;
  logic [NUM_CH-1:0][1:0]        lvl;
  logic                          in_rdy, stall;
  logic [7:0]                    stall_q, stall_d;
  logic                          err_q, err_d;

  // One-hot decode of the destination channel.
  always_comb begin
    dec = 4'b0001 << bus.in_sel;
  end

  // Ready looks only at fullness, never at a same-cycle pop, so there is
  // no path from out_ready to in_ready.
  assign in_rdy = ~full[bus.in_sel];
  assign push   = dec & {NUM_CH{bus.in_valid & in_rdy}};
  assign pop    = valid & bus.out_ready;
  assign stall  = bus.in_valid & ~in_rdy;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    demux1to4_buffered_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .wdata_i (bus.in_data),
      .valid_o (valid[i]),
      .full_o  (full[i]),
      .head_o  (head[i]),
      .level_o (lvl[i])
    );
  end

  assign bus.in_ready     = in_rdy;
  assign bus.out_valid    = valid;
  assign bus.out_data     = head;
  assign bus.level        = lvl;
  assign bus.overflow_err = err_q;

  // Saturating stall counter; one more stalled cycle at 255 trips the flag.
  always_comb begin
    stall_d = '0;
    err_d   = err_q;
    if (stall) begin
      stall_d = (stall_q == 8'hFF) ? 8'hFF : stall_q + 8'd1;
      if (stall_q == 8'hFF) err_d = 1'b1;
    end
  end

  // Stall counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_demux1to4_buffered.sv
// Directed bench for the buffered 1-to-4 demux: a vector table for routing
// and backpressure, then hand sequences for streaming, reset and overflow.
module tb_demux1to4_buffered;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  demux1to4_buffered_if #(.WIDTH(8)) bus ();

  demux1to4_buffered #(.WIDTH(8), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        iv;
    logic [1:0]  sel;
    logic [7:0]  data;
    logic [3:0]  ordy;
    logic        e_irdy;   // before the edge
    logic [3:0]  e_ov;     // after the edge
    logic [7:0]  e_lv;
    logic [31:0] e_od;     // compared only on lanes expected valid
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic iv, logic [1:0] sel, logic [7:0] d,
                              logic [3:0] ordy, logic irdy, logic [3:0] ov,
                              logic [7:0] lv, logic [31:0] od);
    vec_t v;
    v.iv = iv; v.sel = sel; v.data = d; v.ordy = ordy;
    v.e_irdy = irdy; v.e_ov = ov; v.e_lv = lv; v.e_od = od;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic iv, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] ordy);
    bus.in_valid  = iv;
    bus.in_sel    = sel;
    bus.in_data   = d;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  initial begin
    vt[0]  = mk(1, 2'd0, 8'hA5, 4'b0000, 1, 4'b0001, 8'h01, 32'h000000A5);
    vt[1]  = mk(1, 2'd1, 8'h3C, 4'b0000, 1, 4'b0011, 8'h05, 32'h00003CA5);
    vt[2]  = mk(1, 2'd2, 8'hF0, 4'b0000, 1, 4'b0111, 8'h15, 32'h00F03CA5);
    vt[3]  = mk(1, 2'd3, 8'h0F, 4'b0000, 1, 4'b1111, 8'h55, 32'h0FF03CA5);
    vt[4]  = mk(0, 2'd0, 8'h00, 4'b1111, 1, 4'b0000, 8'h00, 32'h00000000);
    vt[5]  = mk(1, 2'd2, 8'h11, 4'b0000, 1, 4'b0100, 8'h10, 32'h00110000);
    vt[6]  = mk(1, 2'd2, 8'h22, 4'b0000, 1, 4'b0100, 8'h20, 32'h00110000);
    vt[7]  = mk(1, 2'd2, 8'h99, 4'b0000, 0, 4'b0100, 8'h20, 32'h00110000);
    vt[8]  = mk(1, 2'd1, 8'h33, 4'b0000, 1, 4'b0110, 8'h24, 32'h00113300);
    vt[9]  = mk(1, 2'd2, 8'h44, 4'b0100, 0, 4'b0110, 8'h14, 32'h00223300);
    vt[10] = mk(1, 2'd2, 8'h44, 4'b0000, 1, 4'b0110, 8'h24, 32'h00223300);
    vt[11] = mk(0, 2'd0, 8'h00, 4'b0100, 1, 4'b0110, 8'h14, 32'h00443300);
    vt[12] = mk(0, 2'd0, 8'h00, 4'b0110, 1, 4'b0000, 8'h00, 32'h00000000);

    drive(0, 2'd0, 8'h00, 4'b0000);
    do_reset();
    chk("reset_out_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("reset_level",     {24'd0, bus.level}, 32'h0);
    chk("reset_in_ready",  {31'd0, bus.in_ready}, 32'h1);
    chk("reset_ovf",       {31'd0, bus.overflow_err}, 32'h0);
    chk("reset_out_data",  bus.out_data, 32'h0);

    // Routing and backpressure table.
    for (int i = 0; i < 13; i++) begin
      logic [31:0] msk;
      drive(vt[i].iv, vt[i].sel, vt[i].data, vt[i].ordy);
      chk($sformatf("v%0d_in_ready", i), {31'd0, bus.in_ready}, {31'd0, vt[i].e_irdy});
      tick();
      chk($sformatf("v%0d_out_valid", i), {28'd0, bus.out_valid}, {28'd0, vt[i].e_ov});
      chk($sformatf("v%0d_level", i), {24'd0, bus.level}, {24'd0, vt[i].e_lv});
      msk = '0;
      for (int c = 0; c < 4; c++) if (vt[i].e_ov[c]) msk[c*8 +: 8] = 8'hFF;
      chk($sformatf("v%0d_out_data", i), bus.out_data & msk, vt[i].e_od & msk);
    end

    // Streaming push+pop at level 1 on channel 3; pointers wrap repeatedly.
    drive(1, 2'd3, 8'd0, 4'b0000);
    tick();
    chk("str_level0", {24'd0, bus.level}, 32'h40);
    for (int k = 1; k < 10; k++) begin
      drive(1, 2'd3, 8'(k), 4'b1000);
      chk($sformatf("str%0d_in_ready", k), {31'd0, bus.in_ready}, 32'h1);
      tick();
      chk($sformatf("str%0d_level", k), {24'd0, bus.level}, 32'h40);
      chk($sformatf("str%0d_head", k), {24'd0, bus.out_data[31:24]}, k);
    end
    drive(0, 2'd0, 8'h00, 4'b1000);
    tick();
    chk("str_drain_valid", {28'd0, bus.out_valid}, 32'h0);

    // Asynchronous reset mid-cycle with channel 0 full.
    drive(1, 2'd0, 8'hAA, 4'b0000);
    tick();
    drive(1, 2'd0, 8'hBB, 4'b0000);
    tick();
    drive(0, 2'd0, 8'h00, 4'b0000);
    chk("mid_pre_level", {24'd0, bus.level}, 32'h02);
    chk("mid_pre_head", {24'd0, bus.out_data[7:0]}, 32'hAA);
    rst_n = 1'b0;
    #1;
    chk("mid_async_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("mid_async_level", {24'd0, bus.level}, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("mid_post_valid", {28'd0, bus.out_valid}, 32'h0);
    chk("mid_post_data", bus.out_data, 32'h0);
    chk("mid_post_ready", {31'd0, bus.in_ready}, 32'h1);

    // Overflow: fill channel 1, then hold a stalled push.
    drive(1, 2'd1, 8'h01, 4'b0000);
    tick();
    drive(1, 2'd1, 8'h02, 4'b0000);
    tick();
    chk("ovf_stalled_ready", {31'd0, bus.in_ready}, 32'h0);
    repeat (255) tick();
    chk("ovf_255_clear", {31'd0, bus.overflow_err}, 32'h0);
    repeat (2) tick();
    chk("ovf_257_set", {31'd0, bus.overflow_err}, 32'h1);
    drive(0, 2'd1, 8'h00, 4'b0010);
    repeat (3) tick();
    chk("ovf_sticky", {31'd0, bus.overflow_err}, 32'h1);
    chk("ovf_drained", {24'd0, bus.level}, 32'h0);
    do_reset();
    chk("ovf_reset_clear", {31'd0, bus.overflow_err}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
